uart_fifo_ctrl: RTL and testbench

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_fifo_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: register-mapped UART with TX and RX byte FIFOs.
//
// Register window (word offsets from BASE):
//   0 DATA   write pushes TX byte, read returns RX head (RE pops)
//   1 STATUS [0] tx_not_full [1] rx_not_empty [2] RXOVR [3] tx_done
//            [4] TXOVF [15:8] rx_count [23:16] tx_count
//   2 DIV    bit period in clk cycles, writable only while tx_done
//   3 CTRL   [0] rx_ie [1] tx_ie [3] loopback; write 1 to [2] clears flags
//
// Ports:
//   clk        sole clock, rising edge
//   rstn       synchronous active-low reset (also reset of uart_tx/uart_rx)
//   WE, RE     write strobe, read/pop qualifier
//   addr, WD   byte address and write data
//   RD         read data, combinational from addr
//   rxd, txd   serial in / serial out (idle high)
//   interrupt  level interrupt
//
// Build option: define UART_FIFO_CTRL_LOOPBACK_EN to enable CTRL[3]
// internal loopback; without it CTRL[3] reads 0 and rxd is always used.
//
// Controller TX FSM:
//   state   | meaning
//   S_IDLE  | waiting for a queued byte and a free transmitter
//   S_START | tx_start held with the popped byte until uart_tx accepts it
//   S_BUSY  | frame in flight, waiting for uart_tx to become available

module uart_tx (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i_period,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_start,
  output logic        o_tx_avai,
  output logic        o_txd
);
  typedef enum logic {S_TX_IDLE, S_TX_SHIFT} tx_state_t;

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [9:0]  r_shift;
  logic [3:0]  r_bits;
  logic [15:0] r_tmr;
  logic        r_txd;
  logic [15:0] w_per_m1;
  logic        w_tc;

  // A zero divisor behaves as one cycle per bit.
  assign w_per_m1 = (i_period == 16'd0) ? 16'd0 : i_period - 16'd1;
  assign w_tc     = (r_tmr == 16'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TX_IDLE:  if (i_tx_start) w_state_nxt = S_TX_SHIFT;
      S_TX_SHIFT: if (w_tc && (r_bits == 4'd0)) w_state_nxt = S_TX_IDLE;
      default:    w_state_nxt = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_TX_IDLE;
      r_shift <= '1;
      r_bits  <= 4'd0;
      r_tmr   <= 16'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_TX_IDLE: begin
          r_txd <= 1'b1;
          if (i_tx_start) begin
            // {stop, data, start}; the start bit goes out immediately.
            r_shift <= {1'b1, i_tx_data, 1'b0};
            r_txd   <= 1'b0;
            r_bits  <= 4'd9;
            r_tmr   <= w_per_m1;
          end
        end
        default: begin
          if (w_tc) begin
            if (r_bits != 4'd0) begin
              r_shift <= {1'b1, r_shift[9:1]};
              r_txd   <= r_shift[1];
              r_bits  <= r_bits - 4'd1;
              r_tmr   <= w_per_m1;
            end
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
      endcase
    end
  end

  // Available again only once the full stop bit has been sent.
  assign o_tx_avai = (r_state == S_TX_IDLE);
  assign o_txd     = r_txd;
endmodule

module uart_rx (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i_period,
  input  logic        i_rxd,
  input  logic        i_rx_clear,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_ready
);
  typedef enum logic [1:0] {S_RX_IDLE, S_RX_START, S_RX_DATA, S_RX_STOP} rx_state_t;

  rx_state_t   r_state;
  rx_state_t   w_state_nxt;
  logic [1:0]  r_sync;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic [2:0]  r_bits;
  logic [15:0] r_tmr;
  logic        r_ready;
  logic        w_rx_s;
  logic        w_tc;
  logic [15:0] w_per_m1;

  assign w_rx_s   = r_sync[1];
  assign w_tc     = (r_tmr == 16'd0);
  assign w_per_m1 = (i_period == 16'd0) ? 16'd0 : i_period - 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RX_IDLE:  if (!w_rx_s) w_state_nxt = S_RX_START;
      S_RX_START: if (w_tc) w_state_nxt = w_rx_s ? S_RX_IDLE : S_RX_DATA;
      S_RX_DATA:  if (w_tc && (r_bits == 3'd0)) w_state_nxt = S_RX_STOP;
      S_RX_STOP:  if (w_tc) w_state_nxt = S_RX_IDLE;
      default:    w_state_nxt = S_RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_RX_IDLE;
      r_sync  <= 2'b11;
      r_shift <= 8'd0;
      r_data  <= 8'd0;
      r_bits  <= 3'd0;
      r_tmr   <= 16'd0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[0], i_rxd};
      case (r_state)
        S_RX_IDLE: r_tmr <= {1'b0, i_period[15:1]};
        S_RX_START: begin
          if (w_tc) begin
            r_tmr  <= w_per_m1;
            r_bits <= 3'd7;
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
        S_RX_DATA: begin
          if (w_tc) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_tmr   <= w_per_m1;
            if (r_bits != 3'd0) r_bits <= r_bits - 3'd1;
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
        default: begin
          if (w_tc) begin
            if (w_rx_s) r_data <= r_shift;
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
      endcase
      // Ready is held until the consumer acknowledges; a new frame wins.
      if (i_rx_clear) r_ready <= 1'b0;
      if ((r_state == S_RX_STOP) && w_tc && w_rx_s) r_ready <= 1'b1;
    end
  end

  assign o_rx_data  = r_data;
  assign o_rx_ready = r_ready;
endmodule

module uart_fifo_ctrl #(
  parameter int unsigned  TX_DEPTH = 16,
  parameter int unsigned  RX_DEPTH = 16,
  parameter logic [15:0]  DIV_INIT = 16'd2604,
  parameter logic [31:0]  BASE     = 32'h7f30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        WE,
  input  logic        RE,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic        rxd,
  output logic        txd,
  output logic        interrupt
);
  localparam int unsigned TXA = $clog2(TX_DEPTH);
  localparam int unsigned TXC = TXA + 1;
  localparam int unsigned RXA = $clog2(RX_DEPTH);
  localparam int unsigned RXC = RXA + 1;
  localparam logic [TXC-1:0] TX_FULL = TXC'(TX_DEPTH);
  localparam logic [RXC-1:0] RX_FULL = RXC'(RX_DEPTH);
  localparam logic [29:0] WA_DATA = BASE[31:2];
  localparam logic [29:0] WA_STAT = BASE[31:2] + 30'd1;
  localparam logic [29:0] WA_DIV  = BASE[31:2] + 30'd2;
  localparam logic [29:0] WA_CTRL = BASE[31:2] + 30'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} ctl_state_t;

  ctl_state_t   r_tx_state;
  ctl_state_t   w_tx_state_nxt;

  logic [7:0]   r_tx_mem [TX_DEPTH];
  logic [TXA-1:0] r_tx_wr, r_tx_rd;
  logic [TXC-1:0] r_tx_cnt;
  logic [7:0]   r_rx_mem [RX_DEPTH];
  logic [RXA-1:0] r_rx_wr, r_rx_rd;
  logic [RXC-1:0] r_rx_cnt;

  logic [7:0]   r_tx_data;
  logic [15:0]  r_div;
  logic         r_rx_ie, r_tx_ie;
  logic         r_rxovr, r_txovf;
  logic         r_rx_clear;

  logic w_sel_data, w_sel_stat, w_sel_div, w_sel_ctrl;
  logic w_tx_push_req, w_tx_push, w_tx_pop, w_tx_full, w_tx_done;
  logic w_rx_push_req, w_rx_push, w_rx_pop, w_rx_full, w_rx_not_empty;
  logic w_ctrl_wr, w_flag_clr;
  logic w_tx_start, w_tx_avai, w_txd_int;
  logic w_rx_ready, w_rx_in, w_lb;
  logic [7:0]  w_rx_data;
  logic [31:0] w_status;
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, addr[1:0], WD[31:16]};

  assign w_sel_data = (addr[31:2] == WA_DATA);
  assign w_sel_stat = (addr[31:2] == WA_STAT);
  assign w_sel_div  = (addr[31:2] == WA_DIV);
  assign w_sel_ctrl = (addr[31:2] == WA_CTRL);

  assign w_ctrl_wr  = WE & w_sel_ctrl;
  assign w_flag_clr = w_ctrl_wr & WD[2];

  // TX FIFO: a push into a full FIFO is still accepted when the FSM pops.
  assign w_tx_full     = (r_tx_cnt == TX_FULL);
  assign w_tx_push_req = WE & w_sel_data;
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_done     = (r_tx_cnt == '0) && (r_tx_state == S_IDLE);

  // RX FIFO: rx_ready is acknowledged one cycle later, so the second
  // cycle of a held rx_ready must not push again.
  assign w_rx_full      = (r_rx_cnt == RX_FULL);
  assign w_rx_not_empty = (r_rx_cnt != '0);
  assign w_rx_push_req  = w_rx_ready & ~r_rx_clear;
  assign w_rx_pop       = RE & w_sel_data & w_rx_not_empty;
  assign w_rx_push      = w_rx_push_req & (~w_rx_full | w_rx_pop);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if ((r_tx_cnt != '0) && w_tx_avai) begin
          w_tx_state_nxt = S_START;
          w_tx_pop       = 1'b1;
        end
      end
      S_START: if (!w_tx_avai) w_tx_state_nxt = S_BUSY;
      S_BUSY:  if (w_tx_avai) w_tx_state_nxt = S_IDLE;
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  assign w_tx_start = (r_tx_state == S_START);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_state <= S_IDLE;
      r_tx_data  <= 8'd0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= WD[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_div      <= DIV_INIT;
      r_rx_ie    <= 1'b0;
      r_tx_ie    <= 1'b0;
      r_rxovr    <= 1'b0;
      r_txovf    <= 1'b0;
      r_rx_clear <= 1'b0;
    end else begin
      r_rx_clear <= w_rx_push_req;
      // Divisor only changes while the line is quiet.
      if (WE && w_sel_div && w_tx_done) r_div <= WD[15:0];
      if (w_ctrl_wr) begin
        r_rx_ie <= WD[0];
        r_tx_ie <= WD[1];
      end
      if (w_flag_clr) begin
        r_rxovr <= 1'b0;
        r_txovf <= 1'b0;
      end
      if (w_rx_push_req && !w_rx_push) r_rxovr <= 1'b1;
      if (w_tx_push_req && !w_tx_push) r_txovf <= 1'b1;
    end
  end

`ifdef UART_FIFO_CTRL_LOOPBACK_EN
  logic r_lb;
  always_ff @(posedge clk) begin
    if (!rstn) r_lb <= 1'b0;
    else if (w_ctrl_wr) r_lb <= WD[3];
  end
  assign w_lb    = r_lb;
  assign w_rx_in = r_lb ? w_txd_int : rxd;
  assign txd     = r_lb ? 1'b1 : w_txd_int;
`else
  assign w_lb    = 1'b0;
  assign w_rx_in = rxd;
  assign txd     = w_txd_int;
`endif

  assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), 3'd0, r_txovf,
                     w_tx_done, r_rxovr, w_rx_not_empty, ~w_tx_full};

  always_comb begin
    RD = 32'd0;
    if (w_sel_data)      RD = w_rx_not_empty ? {24'd0, r_rx_mem[r_rx_rd]} : 32'd0;
    else if (w_sel_stat) RD = w_status;
    else if (w_sel_div)  RD = {16'd0, r_div};
    else if (w_sel_ctrl) RD = {28'd0, w_lb, 1'b0, r_tx_ie, r_rx_ie};
  end

  // Gated by rstn so the line is low for the whole reset assertion.
  assign interrupt = rstn & ((r_rx_ie & (w_rx_not_empty | r_rxovr)) |
                             (r_tx_ie & w_tx_done));

  uart_tx u_tx (
    .clk        (clk),
    .rstn       (rstn),
    .i_period   (r_div),
    .i_tx_data  (r_tx_data),
    .i_tx_start (w_tx_start),
    .o_tx_avai  (w_tx_avai),
    .o_txd      (w_txd_int)
  );

  uart_rx u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .i_period   (r_div),
    .i_rxd      (w_rx_in),
    .i_rx_clear (r_rx_clear),
    .o_rx_data  (w_rx_data),
    .o_rx_ready (w_rx_ready)
  );
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;
  localparam logic [31:0] A_DATA = 32'h7f30;
  localparam logic [31:0] A_STAT = 32'h7f34;
  localparam logic [31:0] A_DIV  = 32'h7f38;
  localparam logic [31:0] A_CTRL = 32'h7f3c;
`ifdef UART_FIFO_CTRL_LOOPBACK_EN
  localparam logic [31:0] LB_BIT = 32'd8;
`else
  localparam logic [31:0] LB_BIT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rstn, WE, RE, rxd, txd, interrupt;
  logic [31:0] addr, WD, RD;

  int n_vec = 0;
  int n_err = 0;
  int tb_period = 16;
  logic [7:0] mon_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];
  logic       model_ovr;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [31:0] raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_INIT(16'd2604), .BASE(32'h7f30)) dut (
    .clk(clk), .rstn(rstn), .WE(WE), .RE(RE), .addr(addr), .WD(WD), .RD(RD),
    .rxd(rxd), .txd(txd), .interrupt(interrupt)
  );

  // Independent serial receiver on the txd pin.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        repeat (tb_period / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (tb_period) @(negedge clk);
          b[i] = txd;
        end
        repeat (tb_period) @(negedge clk);
        mon_q.push_back(b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = RD;
  endtask

  task automatic data_pop(output logic [31:0] d);
    addr = A_DATA; RE = 1'b1;
    #1 d = RD;
    @(negedge clk);
    RE = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rxd = 1'b0;
    tick(tb_period);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(tb_period);
    end
    rxd = 1'b1;
    tick(tb_period + 4);
  endtask

  task automatic wait_status(input int budget, input logic [31:0] mask,
                             input logic [31:0] val, input string nm);
    logic [31:0] s;
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      reg_rd(A_STAT, s);
      if ((s & mask) == val) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_frames();
    chk("tx_frames_n", 32'(mon_q.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < mon_q.size(); i++)
      chk("tx_frame", {24'd0, mon_q[i]}, {24'd0, tx_exp[i]});
    mon_q.delete();
    tx_exp.delete();
  endtask

  initial begin : main
    logic [31:0] d;
    logic [7:0]  b;
    int lows, tx_writes;

    rstn = 1'b0; WE = 1'b0; RE = 1'b0; addr = 32'd0; WD = 32'd0; rxd = 1'b1;
    tick(3);
    chk("irq_in_reset", {31'd0, interrupt}, 32'd0);
    rstn = 1'b1;
    tick(1);

    reg_rd(A_STAT, d); chk("reset_status", d, 32'h0000_0009);
    reg_rd(A_DIV, d);  chk("reset_div", d, 32'd2604);
    chk("reset_irq", {31'd0, interrupt}, 32'd0);
    chk("reset_txd", {31'd0, txd}, 32'd1);

    // Register map vectors; DIV ends at 16 to keep frames short.
    tbl[0] = '{1'b1, A_CTRL,        32'd3,         A_CTRL, 32'd3,  1'b1};
    tbl[1] = '{1'b1, A_CTRL,        32'hFFFF_FFF8, A_CTRL, LB_BIT, 1'b0};
    tbl[2] = '{1'b1, A_CTRL,        32'd0,         A_CTRL, 32'd0,  1'b0};
    tbl[3] = '{1'b1, 32'h7f40,      32'hFFFF_FFFF, 32'h7f40, 32'd0, 1'b0};
    tbl[4] = '{1'b1, 32'h7f2c,      32'h1234,      32'h7f2c, 32'd0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         32'h0,         32'h7f35, 32'h9, 1'b0};
    tbl[6] = '{1'b1, A_DIV,         32'hABCD_0010, A_DIV,  32'd16, 1'b0};
    tbl[7] = '{1'b1, 32'h0001_7f38, 32'd5,         A_DIV,  32'd16, 1'b0};
    tbl[8] = '{1'b0, 32'h0,         32'h0,         32'h7f33, 32'd0, 1'b0};
    tbl[9] = '{1'b0, 32'h0,         32'h0,         32'h0001_7f34, 32'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) reg_wr(tbl[i].waddr, tbl[i].wd);
      reg_rd(tbl[i].raddr, d);
      chk($sformatf("tbl_rd[%0d]", i), d, tbl[i].exp);
      chk($sformatf("tbl_irq[%0d]", i), {31'd0, interrupt}, {31'd0, tbl[i].exp_irq});
    end
    tb_period = 16;

    // Three back-to-back writes: the head is popped on the second edge.
    mon_q.delete();
    reg_wr(A_DATA, 32'h55); reg_wr(A_DATA, 32'hA3); reg_wr(A_DATA, 32'h0F);
    tx_exp.push_back(8'h55); tx_exp.push_back(8'hA3); tx_exp.push_back(8'h0F);
    reg_rd(A_STAT, d); chk("b2b_status", d, 32'h0002_0001);
    wait_status(1000, 32'h8, 32'h8, "b2b_done");
    check_frames();
    reg_wr(A_CTRL, 32'd2);
    chk("tx_irq", {31'd0, interrupt}, 32'd1);
    reg_wr(A_CTRL, 32'd0);
    chk("tx_irq_off", {31'd0, interrupt}, 32'd0);

    // Overflow: one byte in flight, then 17 writes into a stalled FIFO.
    reg_wr(A_DATA, 32'h11); tx_exp.push_back(8'h11);
    wait_status(50, 32'h00FF_0008, 32'h0, "ovf_busy");
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      reg_wr(A_DATA, {24'd0, b});
      if (i < 16) tx_exp.push_back(b);
    end
    reg_rd(A_STAT, d); chk("ovf_status", d, 32'h0010_0010);
    reg_wr(A_CTRL, 32'd4);
    reg_rd(A_STAT, d); chk("ovf_cleared", d & 32'h10, 32'd0);
    wait_status(4000, 32'h8, 32'h8, "ovf_done");
    check_frames();

    // Divisor locked while transmitting.
    reg_wr(A_DATA, 32'h5A); tx_exp.push_back(8'h5A);
    wait_status(50, 32'h00FF_0008, 32'h0, "div_busy");
    reg_wr(A_DIV, 32'd100);
    reg_rd(A_DIV, d); chk("div_locked", d, 32'd16);
    wait_status(400, 32'h8, 32'h8, "div_done");
    check_frames();
    reg_wr(A_DIV, 32'd100);
    reg_rd(A_DIV, d); chk("div_load", d, 32'd100);
    reg_wr(A_DIV, 32'd16);
    reg_rd(A_DIV, d); chk("div_restore", d, 32'd16);

    // RX overrun: 17 frames, no reads.
    rx_model.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_rx(b);
      if (i < 16) rx_model.push_back(b);
    end
    reg_rd(A_STAT, d); chk("rxovr_status", d, 32'h0000_100F);
    reg_wr(A_CTRL, 32'd1);
    chk("rx_irq", {31'd0, interrupt}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      data_pop(d);
      chk("rx_pop", d, (i < 16) ? {24'd0, rx_model[i]} : 32'd0);
    end
    reg_wr(A_CTRL, 32'd4);
    reg_rd(A_STAT, d); chk("rx_cleared", d, 32'h0000_0009);
    chk("rx_irq_off", {31'd0, interrupt}, 32'd0);

    // Randomized mix against a queue model of the RX FIFO and TX stream.
    rx_model.delete(); model_ovr = 1'b0; tx_writes = 0;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0, 4: begin
          b = 8'($urandom);
          send_rx(b);
          if (rx_model.size() < 16) rx_model.push_back(b);
          else model_ovr = 1'b1;
        end
        1: begin
          data_pop(d);
          chk("rand_pop", d, (rx_model.size() > 0) ? {24'd0, rx_model.pop_front()} : 32'd0);
        end
        2: begin
          reg_rd(A_STAT, d);
          chk("rand_status", d & 32'h0000_FF16,
              (32'(rx_model.size()) << 8) | ({31'd0, model_ovr} << 2) |
              ((rx_model.size() > 0) ? 32'd2 : 32'd0));
          tick(1);
        end
        default: begin
          if (tx_writes < 12) begin
            b = 8'($urandom);
            reg_wr(A_DATA, {24'd0, b});
            tx_exp.push_back(b);
            tx_writes++;
          end else begin
            tick(1);
          end
        end
      endcase
    end
    wait_status(3000, 32'h8, 32'h8, "rand_done");
    check_frames();
    while (rx_model.size() > 0) begin
      data_pop(d);
      chk("rand_drain", d, {24'd0, rx_model.pop_front()});
    end

`ifdef UART_FIFO_CTRL_LOOPBACK_EN
    reg_wr(A_CTRL, 32'd4);
    reg_wr(A_CTRL, 32'd9);
    reg_wr(A_DATA, 32'hC3);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      if (txd !== 1'b1) lows++;
      tick(1);
    end
    chk("lb_txd_idle", 32'(lows), 32'd0);
    wait_status(400, 32'h2, 32'h2, "lb_rx");
    chk("lb_irq", {31'd0, interrupt}, 32'd1);
    data_pop(d); chk("lb_data", d, 32'hC3);
    reg_wr(A_CTRL, 32'd0);
    mon_q.delete();
`endif

    // Reset in the middle of a frame.
    reg_wr(A_CTRL, 32'd2);
    reg_wr(A_DATA, 32'h81);
    tick(40);
    rstn = 1'b0;
    tick(1);
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_irq", {31'd0, interrupt}, 32'd0);
    rstn = 1'b1;
    reg_rd(A_STAT, d); chk("midrst_status", d, 32'h0000_0009);
    reg_rd(A_DIV, d);  chk("midrst_div", d, 32'd2604);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      if (txd !== 1'b1) lows++;
      tick(1);
    end
    chk("midrst_idle", 32'(lows), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
